// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-stage engine: access opcodes, FSM states,
// and the byte-lane helpers that stores and the load aligner both use.
package mem_access_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } memState_t;

  // sizeLog2: 0 = byte, 1 = half, 2 = word
  typedef struct packed {
    logic       legal;
    logic       isLoad;
    logic [1:0] sizeLog2;
  } opInfo_t;

  // A load code is only legal with MemRead alone, a store code with MemWrite alone.
  function automatic opInfo_t decodeOp(input logic [5:0] op, input logic rd, input logic wr);
    opInfo_t info;
    info = '0;
    case (op)
      OP_LB, OP_LBU: begin info.legal = rd & ~wr; info.isLoad = 1'b1; info.sizeLog2 = 2'd0; end
      OP_LH, OP_LHU: begin info.legal = rd & ~wr; info.isLoad = 1'b1; info.sizeLog2 = 2'd1; end
      OP_LW:         begin info.legal = rd & ~wr; info.isLoad = 1'b1; info.sizeLog2 = 2'd2; end
      OP_SB:         begin info.legal = wr & ~rd; info.sizeLog2 = 2'd0; end
      OP_SH:         begin info.legal = wr & ~rd; info.sizeLog2 = 2'd1; end
      OP_SW:         begin info.legal = wr & ~rd; info.sizeLog2 = 2'd2; end
      default:       info = '0;
    endcase
    return info;
  endfunction

  function automatic logic isAligned(input logic [1:0] sizeLog2, input logic [1:0] offset);
    case (sizeLog2)
      2'd0:    return 1'b1;
      2'd1:    return ~offset[0];
      default: return offset == 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] laneEnables(input logic [1:0] sizeLog2, input logic [1:0] offset);
    case (sizeLog2)
      2'd0:    return 4'b0001 << offset;
      2'd1:    return offset[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicateStore(input logic [1:0] sizeLog2, input logic [31:0] data);
    case (sizeLog2)
      2'd0:    return {4{data[7:0]}};
      2'd1:    return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic [31:0] alignLoad(input logic [31:0] rdata, input logic [1:0] offset,
                                            input logic [5:0] op);
    logic [31:0] shifted;
    logic [15:0] half;
    shifted = rdata >> {offset, 3'b000};
    half    = offset[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      OP_LB:   return {{24{shifted[7]}}, shifted[7:0]};
      OP_LBU:  return {24'd0, shifted[7:0]};
      OP_LH:   return {{16{half[15]}}, half};
      OP_LHU:  return {16'd0, half};
      default: return rdata;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_aligner.sv
// Combinational load aligner: picks the addressed lane(s) out of the memory word
// and sign/zero-extends them according to the load type.
module load_aligner
  import mem_access_pkg::*;
(
  input  logic [31:0] memRdata,
  input  logic [1:0]  byteOffset,
  input  logic [5:0]  memControl,
  output logic [31:0] loadData
);

  assign loadData = alignLoad(memRdata, byteOffset, memControl);

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage engine: issues loads/stores over a req/ack port, stalls upstream until
// the ack arrives (issue cycle + wait cycles), then presents the result for one DONE cycle.
module mem_access_unit
  import mem_access_pkg::*;
(
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [31:0] MemWriteData_IN,
  input  logic [5:0]  MemControl_IN,
  input  logic        MemRead_IN,
  input  logic        MemWrite_IN,
  input  logic [31:0] ALUResult_IN,
  input  logic [4:0]  WriteRegister_IN,
  input  logic        WriteEnable_IN,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [3:0]  MEM_BE,
  output logic [31:0] MEM_WDATA,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDATA,
  output logic [31:0] WriteData_OUT,
  output logic [4:0]  WriteRegister_OUT,
  output logic        WriteEnable_OUT,
  output logic        STALL_OUT,
  output logic        ADDR_ERR_OUT
);

  memState_t   state;
  opInfo_t     opInfo;
  logic        memOp, accessOk, issueValid;
  logic        stall, addrErr;
  logic [31:0] reqAddr, reqWdata;
  logic [3:0]  reqBe;

  logic [31:0] capAddr, capWdata, loadData;
  logic [3:0]  capBe;
  logic [1:0]  capOffset;
  logic [5:0]  capOp;
  logic        capWe, capIsLoad;

  logic [1:0]  alignOffset;
  logic [5:0]  alignOp;
  logic [31:0] alignedData;

  assign opInfo     = decodeOp(MemControl_IN, MemRead_IN, MemWrite_IN);
  assign memOp      = MemRead_IN | MemWrite_IN;
  assign accessOk   = opInfo.legal & isAligned(opInfo.sizeLog2, ALUResult_IN[1:0]);
  assign issueValid = (state == ST_IDLE) & memOp & accessOk;

  assign reqAddr  = {ALUResult_IN[31:2], 2'b00};
  assign reqBe    = laneEnables(opInfo.sizeLog2, ALUResult_IN[1:0]);
  assign reqWdata = replicateStore(opInfo.sizeLog2, MemWriteData_IN);

  // An ack in the issue cycle is aligned against the live inputs; later acks use the captured copy.
  assign alignOffset = (state == ST_IDLE) ? ALUResult_IN[1:0] : capOffset;
  assign alignOp     = (state == ST_IDLE) ? MemControl_IN     : capOp;

  load_aligner uAligner (
    .memRdata   (MEM_RDATA),
    .byteOffset (alignOffset),
    .memControl (alignOp),
    .loadData   (alignedData)
  );

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      capAddr   <= '0;
      capWdata  <= '0;
      capBe     <= '0;
      capOffset <= '0;
      capOp     <= '0;
      capWe     <= 1'b0;
      capIsLoad <= 1'b0;
      loadData  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (issueValid) begin
            capAddr   <= reqAddr;
            capWdata  <= reqWdata;
            capBe     <= reqBe;
            capOffset <= ALUResult_IN[1:0];
            capOp     <= MemControl_IN;
            capWe     <= MemWrite_IN;
            capIsLoad <= opInfo.isLoad;
            if (MEM_ACK) begin
              loadData <= alignedData;
              state    <= ST_DONE;
            end else begin
              state    <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (MEM_ACK) begin
            loadData <= alignedData;
            state    <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    MEM_REQ       = 1'b0;
    MEM_WE        = MemWrite_IN;
    MEM_ADDR      = reqAddr;
    MEM_BE        = reqBe;
    MEM_WDATA     = reqWdata;
    stall         = 1'b0;
    addrErr       = 1'b0;
    WriteData_OUT = ALUResult_IN;
    case (state)
      ST_IDLE: begin
        MEM_REQ = issueValid;
        stall   = issueValid;
        addrErr = memOp & ~accessOk;
      end
      ST_WAIT: begin
        MEM_REQ   = 1'b1;
        MEM_WE    = capWe;
        MEM_ADDR  = capAddr;
        MEM_BE    = capBe;
        MEM_WDATA = capWdata;
        stall     = 1'b1;
      end
      ST_DONE: begin
        MEM_WE    = capWe;
        MEM_ADDR  = capAddr;
        MEM_BE    = capBe;
        MEM_WDATA = capWdata;
        if (capIsLoad) WriteData_OUT = loadData;
      end
      default: ;
    endcase
    if (RESET) begin
      MEM_REQ = 1'b0;
      stall   = 1'b0;
      addrErr = 1'b0;
    end
  end

  assign STALL_OUT         = stall;
  assign ADDR_ERR_OUT      = addrErr;
  assign WriteRegister_OUT = WriteRegister_IN;
  assign WriteEnable_OUT   = WriteEnable_IN & ~stall & ~addrErr & ~RESET;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus random loads/stores/illegal ops,
// checked cycle by cycle against a transaction-level reference model.
module tb_mem_access_unit;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic [31:0] MemWriteData_IN;
  logic [5:0]  MemControl_IN;
  logic        MemRead_IN, MemWrite_IN;
  logic [31:0] ALUResult_IN;
  logic [4:0]  WriteRegister_IN;
  logic        WriteEnable_IN;
  logic        MEM_REQ, MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [3:0]  MEM_BE;
  logic [31:0] MEM_WDATA;
  logic        MEM_ACK;
  logic [31:0] MEM_RDATA;
  logic [31:0] WriteData_OUT;
  logic [4:0]  WriteRegister_OUT;
  logic        WriteEnable_OUT, STALL_OUT, ADDR_ERR_OUT;

  int nCompared = 0;
  int nMismatch = 0;

  always #5 CLOCK = ~CLOCK;

  mem_access_unit dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .MemWriteData_IN(MemWriteData_IN), .MemControl_IN(MemControl_IN),
    .MemRead_IN(MemRead_IN), .MemWrite_IN(MemWrite_IN),
    .ALUResult_IN(ALUResult_IN), .WriteRegister_IN(WriteRegister_IN),
    .WriteEnable_IN(WriteEnable_IN),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_BE(MEM_BE),
    .MEM_WDATA(MEM_WDATA), .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
    .WriteData_OUT(WriteData_OUT), .WriteRegister_OUT(WriteRegister_OUT),
    .WriteEnable_OUT(WriteEnable_OUT), .STALL_OUT(STALL_OUT), .ADDR_ERR_OUT(ADDR_ERR_OUT)
  );

  task automatic expectEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatch++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int opBytes(input logic [5:0] op);
    case (op)
      6'h20, 6'h24, 6'h28: return 1;
      6'h21, 6'h25, 6'h29: return 2;
      6'h23, 6'h2B:        return 4;
      default:             return 0;
    endcase
  endfunction

  function automatic bit opIsLoad(input logic [5:0] op);
    return op == 6'h20 || op == 6'h21 || op == 6'h23 || op == 6'h24 || op == 6'h25;
  endfunction

  function automatic bit opIsStore(input logic [5:0] op);
    return op == 6'h28 || op == 6'h29 || op == 6'h2B;
  endfunction

  // Drives one instruction from the EXE/MEM register, plays the memory with the given
  // ack delay (0 = ack in the issue cycle) and checks every cycle until it retires.
  task automatic runOp(input string tag, input logic [5:0] op, input logic rd, input logic wr,
                       input logic [31:0] alu, input logic [31:0] wdat, input logic weIn,
                       input int ackDelay, input logic [31:0] rdata);
    int nb;
    bit ld, legal, aligned, memop;
    logic [31:0] expBe, expWd, expRes;
    logic [4:0] wreg;
    longint unsigned fieldMask, v;

    nb      = opBytes(op);
    ld      = opIsLoad(op);
    memop   = rd | wr;
    legal   = (ld && rd && !wr) || (opIsStore(op) && wr && !rd);
    aligned = (nb != 0) && ((alu % nb) == 0);
    expBe   = ((32'd1 << nb) - 32'd1) << alu[1:0];
    expWd   = (nb == 1) ? wdat[7:0] * 32'h01010101 :
              (nb == 2) ? wdat[15:0] * 32'h00010001 : wdat;
    fieldMask = (64'd1 << (8 * nb)) - 64'd1;
    v = (64'(rdata) >> (8 * alu[1:0])) & fieldMask;
    if ((op == 6'h20 || op == 6'h21) && v[8 * nb - 1]) v = v | ~fieldMask;
    expRes = v[31:0];
    wreg   = 5'($urandom_range(0, 31));

    MemControl_IN = op; MemRead_IN = rd; MemWrite_IN = wr; ALUResult_IN = alu;
    MemWriteData_IN = wdat; WriteRegister_IN = wreg; WriteEnable_IN = weIn;

    if (!memop || !(legal && aligned)) begin
      MEM_ACK = 1'($urandom_range(0, 1)); MEM_RDATA = $urandom;
      @(negedge CLOCK);
      expectEq({tag, ".req"},   32'(MEM_REQ), 32'd0);
      expectEq({tag, ".stall"}, 32'(STALL_OUT), 32'd0);
      expectEq({tag, ".err"},   32'(ADDR_ERR_OUT), 32'(memop));
      expectEq({tag, ".we"},    32'(WriteEnable_OUT), memop ? 32'd0 : 32'(weIn));
      expectEq({tag, ".wreg"},  32'(WriteRegister_OUT), 32'(wreg));
      if (!memop) expectEq({tag, ".wd"}, WriteData_OUT, alu);
      @(posedge CLOCK); #1;
    end else begin
      for (int c = 0; c <= ackDelay; c++) begin
        MEM_ACK   = (c == ackDelay);
        MEM_RDATA = (c == ackDelay) ? rdata : $urandom;
        @(negedge CLOCK);
        expectEq({tag, ".req"},   32'(MEM_REQ), 32'd1);
        expectEq({tag, ".stall"}, 32'(STALL_OUT), 32'd1);
        expectEq({tag, ".err"},   32'(ADDR_ERR_OUT), 32'd0);
        expectEq({tag, ".mwe"},   32'(MEM_WE), 32'(wr));
        expectEq({tag, ".addr"},  MEM_ADDR, {alu[31:2], 2'b00});
        expectEq({tag, ".be"},    32'(MEM_BE), expBe);
        expectEq({tag, ".weoff"}, 32'(WriteEnable_OUT), 32'd0);
        if (wr) expectEq({tag, ".wdata"}, MEM_WDATA, expWd);
        @(posedge CLOCK); #1;
      end
      MEM_ACK = 1'($urandom_range(0, 1)); MEM_RDATA = $urandom;
      @(negedge CLOCK);
      expectEq({tag, ".done.req"},   32'(MEM_REQ), 32'd0);
      expectEq({tag, ".done.stall"}, 32'(STALL_OUT), 32'd0);
      expectEq({tag, ".done.wd"},    WriteData_OUT, ld ? expRes : alu);
      expectEq({tag, ".done.we"},    32'(WriteEnable_OUT), 32'(weIn));
      expectEq({tag, ".done.wreg"},  32'(WriteRegister_OUT), 32'(wreg));
      @(posedge CLOCK); #1;
    end
  endtask

  logic [5:0] codes [11] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B,
                             6'h22, 6'h00, 6'h2A};

  initial begin
    logic [5:0] rop;
    logic rrd, rwr;
    logic [31:0] ralu;

    RESET = 1'b1; MEM_ACK = 1'b0; MEM_RDATA = '0;
    MemControl_IN = 6'h23; MemRead_IN = 1'b1; MemWrite_IN = 1'b0; ALUResult_IN = 32'h100;
    MemWriteData_IN = '0; WriteRegister_IN = 5'd3; WriteEnable_IN = 1'b1;
    @(posedge CLOCK); #1;
    @(negedge CLOCK);
    expectEq("rst.req",   32'(MEM_REQ), 32'd0);
    expectEq("rst.stall", 32'(STALL_OUT), 32'd0);
    expectEq("rst.we",    32'(WriteEnable_OUT), 32'd0);
    ALUResult_IN = 32'h102;
    @(negedge CLOCK);
    expectEq("rst.err",   32'(ADDR_ERR_OUT), 32'd0);
    expectEq("rst.req2",  32'(MEM_REQ), 32'd0);
    @(posedge CLOCK); #1;
    RESET = 1'b0;

    runOp("lw_wait",  6'h23, 1, 0, 32'h100, 32'h0, 1, 2, 32'hDEADBEEF);
    runOp("lb",       6'h20, 1, 0, 32'h103, 32'h0, 1, 0, 32'h80FF0000);
    runOp("lbu",      6'h24, 1, 0, 32'h103, 32'h0, 1, 1, 32'h80FF0000);
    runOp("lh",       6'h21, 1, 0, 32'h102, 32'h0, 1, 0, 32'h80FF0000);
    runOp("sb",       6'h28, 0, 1, 32'h201, 32'hAB, 0, 0, 32'h0);
    runOp("lw_mis",   6'h23, 1, 0, 32'h102, 32'h0, 1, 0, 32'h0);
    runOp("sh_mis",   6'h29, 0, 1, 32'h301, 32'h1234, 0, 0, 32'h0);
    runOp("add",      6'h00, 0, 0, 32'h1234, 32'h0, 1, 0, 32'h0);
    runOp("sw_b2b",   6'h2B, 0, 1, 32'h400, 32'hCAFEF00D, 0, 1, 32'h0);
    runOp("lhu_b2b",  6'h25, 1, 0, 32'h402, 32'h0, 1, 0, 32'hF00D8001);

    // Reset lands in the second WAIT cycle; the following ack must be ignored.
    MemControl_IN = 6'h23; MemRead_IN = 1'b1; MemWrite_IN = 1'b0; ALUResult_IN = 32'h500;
    WriteEnable_IN = 1'b1; MEM_ACK = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLOCK);
      expectEq("rstw.req",   32'(MEM_REQ), 32'd1);
      expectEq("rstw.stall", 32'(STALL_OUT), 32'd1);
      @(posedge CLOCK); #1;
    end
    RESET = 1'b1;
    @(negedge CLOCK);
    expectEq("rstw.inrst.req",   32'(MEM_REQ), 32'd0);
    expectEq("rstw.inrst.stall", 32'(STALL_OUT), 32'd0);
    expectEq("rstw.inrst.we",    32'(WriteEnable_OUT), 32'd0);
    @(posedge CLOCK); #1;
    RESET = 1'b0; MemRead_IN = 1'b0; MemControl_IN = 6'h00; ALUResult_IN = 32'h0000A5A5;
    WriteEnable_IN = 1'b0;
    for (int c = 0; c < 2; c++) begin
      MEM_ACK = (c == 0); MEM_RDATA = 32'h11223344;
      @(negedge CLOCK);
      expectEq("rstw.late.req",   32'(MEM_REQ), 32'd0);
      expectEq("rstw.late.stall", 32'(STALL_OUT), 32'd0);
      expectEq("rstw.late.err",   32'(ADDR_ERR_OUT), 32'd0);
      expectEq("rstw.late.we",    32'(WriteEnable_OUT), 32'd0);
      expectEq("rstw.late.wd",    WriteData_OUT, 32'h0000A5A5);
      @(posedge CLOCK); #1;
    end
    MEM_ACK = 1'b0;

    for (int i = 0; i < 250; i++) begin
      rop  = codes[$urandom_range(0, 10)];
      rrd  = opIsLoad(rop);
      rwr  = opIsStore(rop);
      if (!rrd && !rwr) begin
        rrd = 1'($urandom_range(0, 1));
        rwr = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 9) == 0) begin rrd = 1'b0; rwr = 1'b0; end
      if ($urandom_range(0, 19) == 0) begin rrd = 1'b1; rwr = 1'b1; end
      ralu = $urandom;
      if ($urandom_range(0, 1) == 1) ralu[1:0] = 2'b00;
      runOp("rand", rop, rrd, rwr, ralu, $urandom, 1'($urandom_range(0, 1)),
            $urandom_range(0, 3), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage engine that consumes the EXE/MEM pipeline register outputs and performs loads and stores against a word-wide data-memory port with a request/acknowledge handshake. Generates byte enables and lane-replicated store data, and aligns and sign/zero-extends load data. Stalls the upstream pipeline while an access is outstanding, flags misaligned accesses, and presents the write-back result (load data or ALU result) to MEM/WB.

## Interface
- No parameters. Data width is fixed at 32; the memory port is little-endian (addr[1:0]=0 is lane [7:0]).
- CLOCK  in  1  system clock; all state changes on rising edge
- RESET  in  1  synchronous, active-high reset
- MemWriteData_IN  in  32  store data from EXE/MEM
- MemControl_IN  in  6  access type (MIPS opcode; codes below)
- MemRead_IN / MemWrite_IN  in  1 each  load / store valid
- ALUResult_IN  in  32  effective address, or result for non-memory ops
- WriteRegister_IN  in  5  destination register
- WriteEnable_IN  in  1  register write-back enable
- MEM_REQ  out  1  access request
- MEM_WE  out  1  1 = write, 0 = read
- MEM_ADDR  out  32  word address, bits [1:0] always 0
- MEM_BE  out  4  byte enables (reads: lanes used)
- MEM_WDATA  out  32  lane-replicated store data
- MEM_ACK  in  1  access complete; read data valid in the same cycle
- MEM_RDATA  in  32  read data
- WriteData_OUT  out  32  to MEM/WB: load result or ALUResult_IN
- WriteRegister_OUT  out  5  = WriteRegister_IN
- WriteEnable_OUT  out  1  gated write-back enable
- STALL_OUT  out  1  to hazard unit; holds PC, IF/ID, ID/EXE, EXE/MEM
- ADDR_ERR_OUT  out  1  misaligned/illegal access, one-cycle pulse

## Operation
- Codes: LB=6'h20, LH=6'h21, LW=6'h23, LBU=6'h24, LHU=6'h25, SB=6'h28, SH=6'h29, SW=6'h2B. Any other code with MemRead_IN/MemWrite_IN set is illegal.
- Access valid = (MemRead_IN | MemWrite_IN) & legal code & aligned. Word aligned iff addr[1:0]=0; half iff addr[0]=0; byte always.
- Invalid access: no MEM_REQ, ADDR_ERR_OUT=1 that cycle, WriteEnable_OUT=0, STALL_OUT=0.
- Stores: SB → MEM_BE = 1<<addr[1:0], WDATA = {4{byte}}; SH → BE = addr[1] ? 4'b1100 : 4'b0011, WDATA = {2{half}}; SW → BE = 4'b1111.
- Loads: select lane(s) by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
- FSM states IDLE, WAIT, DONE:
  - IDLE, valid access: MEM_REQ=1 combinationally from inputs; capture addr/BE/WDATA/WE/type. ACK=1 → DONE (latch aligned read data), else → WAIT. STALL_OUT=1.
  - WAIT: MEM_REQ=1 driven from captured copies; STALL_OUT=1; on ACK latch read data → DONE.
  - DONE: MEM_REQ=0, STALL_OUT=0; WriteData_OUT = latched load data (loads) or ALUResult_IN (stores); → IDLE unconditionally. This prevents re-issuing the held instruction.
- Non-memory op in IDLE: WriteData_OUT = ALUResult_IN, no stall, zero added latency.
- WriteEnable_OUT = WriteEnable_IN & ~STALL_OUT & ~ADDR_ERR_OUT (a bubble is presented while stalled).

## Timing
- Reset: state=IDLE, captured and load registers=0. While RESET=1, MEM_REQ, STALL_OUT, ADDR_ERR_OUT and WriteEnable_OUT are forced to 0.
- Minimum memory op: 2 cycles (issue cycle with ACK, then DONE); each wait cycle adds one. Stall cycles = cycles before DONE.
- MEM_ADDR/BE/WDATA/WE stay stable from issue through the ACK cycle inclusive.
- ACK outside IDLE-with-request or WAIT is ignored.
- RESET during WAIT: request is abandoned, state returns to IDLE, and a late ACK is ignored. The memory side must tolerate a dropped request.
- Back-to-back memory ops: the second issues in the IDLE cycle following DONE.

## Structure
- Package mem_access_pkg: opcode constants, FSM state enum, lane-select/extend function.
- One sub-module, load_aligner (combinational: RDATA, addr[1:0], type → 32-bit result), instantiated on the ACK path ahead of the load register.

## Test plan
- LW at 0x100, ACK after 3 cycles, RDATA=0xDEADBEEF → STALL_OUT high 3 cycles; DONE gives WriteData_OUT=0xDEADBEEF, WriteEnable_OUT=1 for one cycle.
- LB at 0x103, RDATA=0x80FF_0000 → 0xFFFFFF80; LBU at the same address → 0x00000080; LH at 0x102 → 0xFFFF80FF.
- SB 0x000000AB at 0x201, ACK same cycle → MEM_ADDR=0x200, MEM_BE=4'b0010, MEM_WDATA=0xABABABAB, one stall cycle.
- LW at 0x102 → ADDR_ERR_OUT=1, no MEM_REQ, WriteEnable_OUT=0, no stall. Also SH at 0x301 → same response.
- ADD result 0x1234, WriteEnable_IN=1 → WriteData_OUT=0x1234 in the same cycle, STALL_OUT=0.
- Assert RESET in the second WAIT cycle, then ACK one cycle later → state IDLE, outputs 0, no DONE, no write-back.
